// File: rtl/uart_frame_decoder.sv
// uart_frame_decoder
// Locks onto a doubled sync byte in a UART byte stream, unpacks NUM_CH
// little-endian channel words plus a button byte, and publishes the whole
// frame at once with a one-cycle strobe. Inter-byte timeouts and checksum
// mismatches bump a saturating error counter.
// Optional feature: define FRAME_CHECKSUM_EN to require a trailing XOR
// checksum byte after the button byte.
module uart_frame_decoder #(
   parameter int         NUM_CH         = 2,
   parameter int         CH_WIDTH       = 11,
   parameter int         NUM_BTN        = 1,
   parameter logic [7:0] SYNC_BYTE      = 8'hAA,
   parameter int         TIMEOUT_CYCLES = 5000000
) (
   input  logic                       clk50,
   input  logic                       nreset,
   input  logic [7:0]                 byteD,
   input  logic                       byte_ready,
   output logic [NUM_CH*CH_WIDTH-1:0] ch_data,
   output logic [NUM_BTN-1:0]         btn,
   output logic                       frame_strobe,
   output logic                       synced,
   output logic [7:0]                 err_count
);

   localparam int BPC = (CH_WIDTH + 7) / 8;
   localparam int CW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int BW  = (BPC > 1) ? $clog2(BPC) : 1;
   localparam int TW  = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_CHAN,
`ifdef FRAME_CHECKSUM_EN
      ST_BTN,
      ST_CHK
`else
      ST_BTN
`endif
   } state_t;

   state_t                       state;
   state_t                       state_next;
   logic                         seq;
   logic                         seq_next;
   logic                         ready_q;
   logic                         accept;
   logic                         commit;
   logic                         fail;
   logic                         last_chan_byte;
   logic [CW-1:0]                ch_idx;
   logic [BW-1:0]                byte_idx;
   logic [TW-1:0]                tcount;
   logic [NUM_CH*CH_WIDTH-1:0]   shadow_ch;
`ifdef FRAME_CHECKSUM_EN
   logic [NUM_BTN-1:0]           shadow_btn;
   logic [7:0]                   chk_acc;
`endif

   assign accept         = byte_ready && !ready_q;
   assign synced         = (state != ST_SYNC);
   assign last_chan_byte = (ch_idx == CW'(NUM_CH - 1)) && (byte_idx == BW'(BPC - 1));

   // State register, sync-sequence flag and byte_ready edge history; the
   // edge register tracks the live level even in reset so a level already
   // high at release is not mistaken for a new byte.
   always_ff @(posedge clk50 or negedge nreset) begin
      if (!nreset) begin
         state   <= ST_SYNC;
         seq     <= 1'b0;
         ready_q <= byte_ready;
      end else begin
         state   <= state_next;
         seq     <= seq_next;
         ready_q <= byte_ready;
      end
   end

   // Next-state decode: timeout expiry abandons the frame unless a byte
   // arrives that very cycle; otherwise each accepted byte walks the frame.
   always_comb begin
      state_next = state;
      seq_next   = seq;
      commit     = 1'b0;
      fail       = 1'b0;
      if ((state != ST_SYNC || seq) && !accept && tcount == TW'(TIMEOUT_CYCLES - 1)) begin
         fail       = 1'b1;
         state_next = ST_SYNC;
         seq_next   = 1'b0;
      end else if (accept) begin
         case (state)
            ST_SYNC: begin
               if (!seq) begin
                  seq_next = (byteD == SYNC_BYTE);
               end else begin
                  seq_next = 1'b0;
                  if (byteD == SYNC_BYTE) state_next = ST_CHAN;
               end
            end
            ST_CHAN: begin
               if (last_chan_byte) state_next = ST_BTN;
            end
            ST_BTN: begin
`ifdef FRAME_CHECKSUM_EN
               state_next = ST_CHK;
`else
               commit     = 1'b1;
               state_next = ST_SYNC;
`endif
            end
`ifdef FRAME_CHECKSUM_EN
            ST_CHK: begin
               state_next = ST_SYNC;
               if (byteD == chk_acc) commit = 1'b1;
               else fail = 1'b1;
            end
`endif
            default: state_next = ST_SYNC;
         endcase
      end
   end

   // Datapath: inter-byte timer, shadow capture of channel bytes, atomic
   // publish on commit and saturating error accounting.
   always_ff @(posedge clk50 or negedge nreset) begin
      if (!nreset) begin
         tcount       <= '0;
         ch_idx       <= '0;
         byte_idx     <= '0;
         shadow_ch    <= '0;
         ch_data      <= '0;
         btn          <= '0;
         frame_strobe <= 1'b0;
         err_count    <= 8'd0;
`ifdef FRAME_CHECKSUM_EN
         shadow_btn   <= '0;
         chk_acc      <= 8'd0;
`endif
      end else begin
         frame_strobe <= commit;
         if (accept || (state_next == ST_SYNC && !seq_next)) tcount <= '0;
         else tcount <= tcount + TW'(1);
         if (fail && err_count != 8'hFF) err_count <= err_count + 8'd1;
         if (state == ST_SYNC) begin
            ch_idx    <= '0;
            byte_idx  <= '0;
            shadow_ch <= '0;
`ifdef FRAME_CHECKSUM_EN
            chk_acc   <= 8'd0;
`endif
         end else if (accept && state == ST_CHAN) begin
            for (int c = 0; c < NUM_CH; c++) begin
               for (int k = 0; k < CH_WIDTH; k++) begin
                  if (ch_idx == CW'(c) && byte_idx == BW'(k / 8))
                     shadow_ch[c*CH_WIDTH + k] <= byteD[k % 8];
               end
            end
            if (byte_idx == BW'(BPC - 1)) begin
               byte_idx <= '0;
               ch_idx   <= ch_idx + CW'(1);
            end else begin
               byte_idx <= byte_idx + BW'(1);
            end
`ifdef FRAME_CHECKSUM_EN
            chk_acc <= chk_acc ^ byteD;
         end else if (accept && state == ST_BTN) begin
            shadow_btn <= byteD[NUM_BTN-1:0];
            chk_acc    <= chk_acc ^ byteD;
`endif
         end
         if (commit) begin
            ch_data <= shadow_ch;
`ifdef FRAME_CHECKSUM_EN
            btn     <= shadow_btn;
`else
            btn     <= byteD[NUM_BTN-1:0];
`endif
         end
      end
   end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// tb_uart_frame_decoder
// Byte-level reference model of the frame protocol driven by directed and
// randomized byte streams. Honours FRAME_CHECKSUM_EN when defined.
module tb_uart_frame_decoder;

   localparam int NUM_CH   = 2;
   localparam int CH_WIDTH = 11;
   localparam int NUM_BTN  = 1;
   localparam int TIMEOUT  = 32;
   localparam int BPC      = (CH_WIDTH + 7) / 8;
   localparam int PAY      = NUM_CH * BPC + 1;
`ifdef FRAME_CHECKSUM_EN
   localparam int FRAME_LEN = PAY + 1;
`else
   localparam int FRAME_LEN = PAY;
`endif
   localparam int LONG_GAP = 3 * TIMEOUT;

   logic                       clk50      = 1'b0;
   logic                       nreset     = 1'b0;
   logic                       byte_ready = 1'b0;
   logic [7:0]                 byteD      = 8'h00;
   logic [NUM_CH*CH_WIDTH-1:0] ch_data;
   logic [NUM_BTN-1:0]         btn;
   logic                       frame_strobe;
   logic                       synced;
   logic [7:0]                 err_count;

   int total = 0;
   int bad   = 0;

   int          m_phase = 0;
   logic [7:0]  m_frame[$];
   logic [31:0] m_ch  = 0;
   logic [31:0] m_btn = 0;
   logic [31:0] m_err = 0;
   logic        m_commit = 1'b0;

   logic [7:0] pay_t1 [PAY] = '{8'h34, 8'h05, 8'h78, 8'h02, 8'h01};
   logic [7:0] pay_t2 [PAY] = '{8'h10, 8'h00, 8'h20, 8'h00, 8'h00};
   logic [7:0] pay_t4 [PAY] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h03};

   uart_frame_decoder #(
      .NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .NUM_BTN(NUM_BTN),
      .SYNC_BYTE(8'hAA), .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk50(clk50), .nreset(nreset), .byteD(byteD), .byte_ready(byte_ready),
      .ch_data(ch_data), .btn(btn), .frame_strobe(frame_strobe),
      .synced(synced), .err_count(err_count)
   );

   always #10 clk50 = ~clk50;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic model_err();
      if (m_err < 255) m_err = m_err + 1;
   endtask

   // Frame complete: assemble channels arithmetically from the byte list.
   task automatic model_finish();
      logic [31:0] val;
      logic [31:0] chv;
      logic [7:0]  x;
      chv = 0;
      x   = 8'h00;
      for (int i = 0; i < PAY; i++) x = x ^ m_frame[i];
      for (int c = 0; c < NUM_CH; c++) begin
         val = 0;
         for (int b = 0; b < BPC; b++) val = val | (32'(m_frame[c*BPC + b]) << (8 * b));
         val = val & ((32'd1 << CH_WIDTH) - 1);
         chv = chv | (val << (c * CH_WIDTH));
      end
`ifdef FRAME_CHECKSUM_EN
      if (m_frame[PAY] != x) begin
         model_err();
         return;
      end
`endif
      m_ch     = chv;
      m_btn    = 32'(m_frame[NUM_CH*BPC]) & ((32'd1 << NUM_BTN) - 1);
      m_commit = 1'b1;
   endtask

   task automatic model_byte(input logic [7:0] b);
      m_commit = 1'b0;
      if (m_phase == 0) begin
         if (b == 8'hAA) m_phase = 1;
      end else if (m_phase == 1) begin
         if (b == 8'hAA) begin
            m_phase = 2;
            m_frame.delete();
         end else begin
            m_phase = 0;
         end
      end else begin
         m_frame.push_back(b);
         if (m_frame.size() == FRAME_LEN) begin
            model_finish();
            m_phase = 0;
         end
      end
   endtask

   // One byte: rising ready edge, check one cycle later, then idle gap.
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      @(negedge clk50);
      byteD      = b;
      byte_ready = 1'b1;
      model_byte(b);
      @(negedge clk50);
      checkOutput("strobe", 32'(frame_strobe), 32'(m_commit));
      checkOutput("ch_data", 32'(ch_data), m_ch);
      checkOutput("btn", 32'(btn), m_btn);
      checkOutput("synced", 32'(synced), 32'(m_phase == 2));
      checkOutput("err_count", 32'(err_count), m_err);
      byte_ready = 1'b0;
      @(negedge clk50);
      checkOutput("strobe_width", 32'(frame_strobe), 32'd0);
      repeat (gap) @(negedge clk50);
      if (gap >= LONG_GAP) begin
         if (m_phase != 0) begin
            m_phase = 0;
            model_err();
         end
         checkOutput("to_synced", 32'(synced), 32'd0);
         checkOutput("to_err", 32'(err_count), m_err);
         checkOutput("to_ch_hold", 32'(ch_data), m_ch);
      end
   endtask

   task automatic send_frame(input logic [7:0] pay [PAY], input bit corrupt);
      logic [7:0] x;
      x = 8'h00;
      applyStimulus(8'hAA, 1);
      applyStimulus(8'hAA, $urandom_range(0, 3));
      for (int i = 0; i < PAY; i++) begin
         applyStimulus(pay[i], $urandom_range(0, 3));
         x = x ^ pay[i];
      end
`ifdef FRAME_CHECKSUM_EN
      applyStimulus(corrupt ? ~x : x, 1);
`else
      if (corrupt) x = ~x;
`endif
   endtask

   task automatic applyReset(input logic level, input logic [7:0] d);
      @(negedge clk50);
      byte_ready = level;
      byteD      = d;
      nreset     = 1'b0;
      #1;
      m_phase = 0;
      m_ch    = 0;
      m_btn   = 0;
      m_err   = 0;
      m_frame.delete();
      checkOutput("rst_ch", 32'(ch_data), 32'd0);
      checkOutput("rst_btn", 32'(btn), 32'd0);
      checkOutput("rst_strobe", 32'(frame_strobe), 32'd0);
      checkOutput("rst_synced", 32'(synced), 32'd0);
      checkOutput("rst_err", 32'(err_count), 32'd0);
      repeat (2) @(negedge clk50);
      nreset = 1'b1;
      repeat (2) @(negedge clk50);
      byte_ready = 1'b0;
      @(negedge clk50);
   endtask

   // Bounded run: a hang reports and stops.
   initial begin
      #20000000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios, random traffic, reset corner cases, saturation.
   initial begin
      logic [7:0] pay [PAY];
      int         kind;
      int         n;

      applyReset(1'b0, 8'h00);

      send_frame(pay_t1, 1'b0);
      checkOutput("t1_ch", 32'(ch_data), 32'({11'h278, 11'h534}));
      checkOutput("t1_btn", 32'(btn), 32'd1);

      applyStimulus(8'hAA, 1);
      applyStimulus(8'h55, 1);
      send_frame(pay_t2, 1'b0);
      checkOutput("t2_ch", 32'(ch_data), 32'({11'h020, 11'h010}));
      checkOutput("t2_btn", 32'(btn), 32'd0);

      applyStimulus(8'hAA, 1);
      applyStimulus(8'hAA, 1);
      applyStimulus(8'h11, 1);
      applyStimulus(8'h00, LONG_GAP);
      checkOutput("t3_err", 32'(err_count), 32'd1);
      checkOutput("t3_ch_hold", 32'(ch_data), 32'({11'h020, 11'h010}));
      send_frame(pay_t1, 1'b0);

      send_frame(pay_t4, 1'b0);
      checkOutput("t4_ch", 32'(ch_data), 32'({11'h7FF, 11'h7FF}));
      checkOutput("t4_btn", 32'(btn), 32'd1);

      for (int it = 0; it < 60; it++) begin
         kind = $urandom_range(0, 5);
         for (int i = 0; i < PAY; i++)
            pay[i] = ($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom);
         if (kind <= 2) begin
            send_frame(pay, 1'b0);
         end else if (kind == 3) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
               applyStimulus(($urandom_range(0, 1) == 0) ? 8'hAA : 8'($urandom), $urandom_range(0, 4));
         end else if (kind == 4) begin
            applyStimulus(8'hAA, 1);
            applyStimulus(8'hAA, 1);
            n = $urandom_range(1, PAY - 1);
            for (int i = 0; i < n; i++)
               applyStimulus(pay[i], (i == n - 1) ? LONG_GAP : 1);
         end else begin
            send_frame(pay, 1'b1);
         end
      end

      applyReset(1'b1, 8'hAA);
      foreach (pay_t1[i]) begin
         if (i == 0) applyStimulus(8'hAA, 1);
         applyStimulus(pay_t1[i], 1);
      end
      send_frame(pay_t2, 1'b0);

      applyStimulus(8'hAA, 1);
      applyStimulus(8'hAA, 1);
      applyStimulus(8'h34, 1);
      applyStimulus(8'h05, 1);
      applyReset(1'b0, 8'h00);
      send_frame(pay_t1, 1'b0);

      for (int i = 0; i < 260; i++) applyStimulus(8'hAA, LONG_GAP);
      checkOutput("sat_err", 32'(err_count), 32'd255);
      send_frame(pay_t4, 1'b0);
      checkOutput("sat_err_hold", 32'(err_count), 32'd255);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
